// File: rtl/ct_wsgen_if.sv
// Word-cycle sequencer signal bundle: serial instruction/carry in, timing and select out.
// The sequencer side uses the slave modport; the ROM/A&R side uses master.
interface ct_wsgen_if;
  logic       is;
  logic       carry;
  logic       sync;
  logic       ws;
  logic [3:0] ptr;
  logic       carry_flag;
  logic [5:0] bit_cnt;

  modport master (
    output is, carry,
    input  sync, ws, ptr, carry_flag, bit_cnt
  );

  modport slave (
    input  is, carry,
    output sync, ws, ptr, carry_flag, bit_cnt
  );
endinterface

// File: rtl/ct_wsgen.sv
// C&T word-cycle sequencer: 56-bit-time word counter, SYNC window, serial instruction
// capture, P-pointer ops and field-select decode producing WS for the following word.
module ct_wsgen #(
  parameter int WORD_BITS  = 56,
  parameter int SYNC_FIRST = 45,
  parameter int SYNC_LAST  = 54,
  parameter int P_MAX      = 13
) (
  input  logic        cph2,
  input  logic        rst,
  ct_wsgen_if.slave   bus
);

  localparam logic [5:0] LAST_BIT = 6'(WORD_BITS - 1);
  localparam logic [5:0] SYNC_LO  = 6'(SYNC_FIRST);
  localparam logic [5:0] SYNC_HI  = 6'(SYNC_LAST);
  localparam logic [3:0] P_TOP    = 4'(P_MAX);

  logic [5:0] bit_cnt_reg;
  logic [9:0] ir_sr_reg;
  logic [9:0] exec_ir_reg;
  logic [3:0] ptr_reg;
  logic [3:0] lo_reg;
  logic [3:0] hi_reg;
  logic       ws_en_reg;
  logic       carry_flag_reg;

  logic [3:0] ptr_next;
  logic [3:0] lo_next;
  logic [3:0] hi_next;
  logic       ws_en_next;

  logic       in_window;
  logic       end_of_word;
  logic [3:0] digit;

  assign in_window   = (bit_cnt_reg >= SYNC_LO) && (bit_cnt_reg <= SYNC_HI);
  assign end_of_word = (bit_cnt_reg == LAST_BIT);
  assign digit       = bit_cnt_reg[5:2];

  // Pointer op of the instruction that is finishing execution this word.
  always_comb begin
    ptr_next = ptr_reg;
    if (exec_ir_reg[1:0] == 2'b00) begin
      case (exec_ir_reg[5:0])
        6'b001100: ptr_next = (exec_ir_reg[9:6] > P_TOP) ? P_TOP : exec_ir_reg[9:6];
        6'b011100: ptr_next = (ptr_reg == 4'd0) ? P_TOP : ptr_reg - 4'd1;
        6'b111100: ptr_next = (ptr_reg >= P_TOP) ? 4'd0 : ptr_reg + 4'd1;
        default:   ptr_next = ptr_reg;
      endcase
    end
  end

  // Field decode of the freshly captured instruction, using the already-updated pointer
  // so a P-op immediately followed by a P/WP field sees the new value.
  always_comb begin
    ws_en_next = (ir_sr_reg[1:0] == 2'b10);
    lo_next    = 4'd0;
    hi_next    = 4'd0;
    case (ir_sr_reg[4:2])
      3'b000: begin lo_next = ptr_next; hi_next = ptr_next; end
      3'b001: begin lo_next = 4'd0;     hi_next = ptr_next; end
      3'b010: begin lo_next = 4'd2;     hi_next = 4'd2;     end
      3'b011: begin lo_next = 4'd0;     hi_next = 4'd2;     end
      3'b100: begin lo_next = P_TOP;    hi_next = P_TOP;    end
      3'b101: begin lo_next = 4'd3;     hi_next = 4'd12;    end
      3'b110: begin lo_next = 4'd0;     hi_next = P_TOP;    end
      default: begin lo_next = 4'd3;    hi_next = P_TOP;    end
    endcase
  end

  always_ff @(posedge cph2) begin
    if (rst) begin
      bit_cnt_reg    <= 6'd0;
      ir_sr_reg      <= 10'd0;
      exec_ir_reg    <= 10'd0;
      ptr_reg        <= 4'd0;
      lo_reg         <= 4'd0;
      hi_reg         <= 4'd0;
      ws_en_reg      <= 1'b0;
      carry_flag_reg <= 1'b0;
    end else begin
      bit_cnt_reg <= end_of_word ? 6'd0 : bit_cnt_reg + 6'd1;
      if (in_window) begin
        ir_sr_reg <= {bus.is, ir_sr_reg[9:1]};
      end
      if (end_of_word) begin
        exec_ir_reg    <= ir_sr_reg;
        ptr_reg        <= ptr_next;
        lo_reg         <= lo_next;
        hi_reg         <= hi_next;
        ws_en_reg      <= ws_en_next;
        carry_flag_reg <= bus.carry;
      end
    end
  end

  assign bus.sync       = in_window;
  assign bus.ws         = ws_en_reg && (digit >= lo_reg) && (digit <= hi_reg);
  assign bus.ptr        = ptr_reg;
  assign bus.carry_flag = carry_flag_reg;
  assign bus.bit_cnt    = bit_cnt_reg;

endmodule
